// File: rtl/mem_access_unit_if.sv
// Request, RAM and response signal bundle of mem_access_unit.
// slave = the access unit itself; master = the CPU/RAM side driving it.
interface mem_access_unit_if #(
  parameter int DEPTH_LOG2 = 11
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_sign;
  logic [31:0]           req_addr;
  logic [31:0]           req_wdata;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic                  ram_we;
  logic [3:0]            ram_be;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  modport slave (
    input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, ram_rdata,
    output req_ready, ram_addr, ram_we, ram_be, ram_wdata, rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, ram_rdata,
    input  req_ready, ram_addr, ram_we, ram_be, ram_wdata, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory access unit: byte/half/word loads and stores onto a word-wide sync RAM.
// Optional MEM_ACCESS_UNIT_ALIGN_CHECK_EN: misaligned half/word accesses fault instead of truncating the lane.
//
// state   | meaning
// IDLE    | ready, waiting for req_valid
// ACCESS  | RAM address presented; store writes here
// CAPTURE | load data returned, extract and extend
// RESP    | good response pulse
// ERR     | fault response pulse, no RAM access
module mem_access_unit #(
  parameter int          DEPTH_LOG2 = 11,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input logic clk,
  input logic reset,
  mem_access_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCESS, S_CAPTURE, S_RESP, S_ERR
  } state_t;

  localparam logic [32:0] RANGE_LIMIT = 33'd4 << DEPTH_LOG2;

  state_t                state_q, state_nx;
  logic                  we_q, sign_q;
  logic [1:0]            size_q, lane_q;
  logic [DEPTH_LOG2-1:0] ram_addr_q;
  logic [31:0]           ram_wdata_q, rsp_rdata_q;

  logic [31:0] offset;
  logic [1:0]  lane_eff;
  logic        range_fault, align_fault, fault, accept, store_active;
  logic [31:0] wdata_rep, rdata_shift, load_ext;
  logic [3:0]  be_gen;

  assign offset      = bus.req_addr - BASE_ADDR;
  // negative offsets wrap to huge unsigned values and land here too
  assign range_fault = {1'b0, offset} >= RANGE_LIMIT;
  assign fault       = range_fault || (bus.req_size == 2'd3) || align_fault;
  assign accept      = (state_q == S_IDLE) && bus.req_valid;

`ifdef MEM_ACCESS_UNIT_ALIGN_CHECK_EN
  assign align_fault = ((bus.req_size == 2'd1) && offset[0]) ||
                       ((bus.req_size == 2'd2) && (offset[1:0] != 2'b00));
`else
  assign align_fault = 1'b0;
`endif

  always_comb begin
    lane_eff = offset[1:0];
    case (bus.req_size)
      2'd1:    lane_eff = {offset[1], 1'b0};
      2'd2:    lane_eff = 2'b00;
      default: lane_eff = offset[1:0];
    endcase
  end

  always_comb begin
    wdata_rep = bus.req_wdata;
    case (bus.req_size)
      2'd0:    wdata_rep = {4{bus.req_wdata[7:0]}};
      2'd1:    wdata_rep = {2{bus.req_wdata[15:0]}};
      default: wdata_rep = bus.req_wdata;
    endcase
  end

  always_comb begin
    be_gen = 4'b1111;
    case (size_q)
      2'd0:    be_gen = 4'b0001 << lane_q;
      2'd1:    be_gen = 4'b0011 << lane_q;
      default: be_gen = 4'b1111;
    endcase
  end

  // word loads always have lane 0, so the shifted word equals ram_rdata
  assign rdata_shift = bus.ram_rdata >> {lane_q, 3'b000};

  always_comb begin
    load_ext = rdata_shift;
    case (size_q)
      2'd0:    load_ext = {{24{sign_q & rdata_shift[7]}}, rdata_shift[7:0]};
      2'd1:    load_ext = {{16{sign_q & rdata_shift[15]}}, rdata_shift[15:0]};
      default: load_ext = rdata_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_nx;
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      S_IDLE:    if (bus.req_valid) state_nx = fault ? S_ERR : S_ACCESS;
      S_ACCESS:  state_nx = we_q ? S_RESP : S_CAPTURE;
      S_CAPTURE: state_nx = S_RESP;
      S_RESP:    state_nx = S_IDLE;
      S_ERR:     state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q        <= 1'b0;
      sign_q      <= 1'b0;
      size_q      <= 2'd0;
      lane_q      <= 2'd0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q        <= bus.req_we;
        sign_q      <= bus.req_sign;
        size_q      <= bus.req_size;
        lane_q      <= lane_eff;
        rsp_rdata_q <= '0;
        if (!fault) begin
          ram_addr_q <= offset[DEPTH_LOG2+1:2];
          if (bus.req_we) ram_wdata_q <= wdata_rep;
        end
      end
      if (state_q == S_CAPTURE) rsp_rdata_q <= load_ext;
    end
  end

  // reset gates the strobe so a write coinciding with reset never lands
  assign store_active = (state_q == S_ACCESS) && we_q && !reset;

  always_comb begin
    bus.req_ready = (state_q == S_IDLE);
    bus.ram_we    = store_active;
    bus.ram_be    = store_active ? be_gen : 4'b0000;
    bus.ram_addr  = ram_addr_q;
    bus.ram_wdata = ram_wdata_q;
    bus.rsp_valid = (state_q == S_RESP) || (state_q == S_ERR);
    bus.rsp_err   = (state_q == S_ERR);
    bus.rsp_rdata = rsp_rdata_q;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Parametrised data-memory access unit between the CPU memory stage and a synchronous word-wide data RAM.
- Translates byte addresses into a word index and byte lane, relative to a configurable base, at a configurable RAM depth.
- Generates byte enables and lane-shifted write data for SB/SH/SW.
- Extracts and sign- or zero-extends LB/LBU/LH/LHU/LW results.
- Sequences each access through a small FSM with a valid/ready request handshake and a one-cycle response pulse.

Parameters:
- DEPTH_LOG2, 11, RAM word-index width (RAM holds 2^DEPTH_LOG2 32-bit words).
- BASE_ADDR, 32'h0000_0000, byte address mapped to RAM word 0; must be word aligned.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- req_sign  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- ram_addr  output  DEPTH_LOG2  RAM word index
- ram_we  output  1  RAM write strobe
- ram_be  output  4  RAM byte enables; bit k enables bits 8k+7:8k
- ram_wdata  output  32  lane-shifted write data
- ram_rdata  input  32  RAM read data, valid one cycle after ram_addr is presented
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  extended load result; 0 for stores and errors
- rsp_err  output  1  qualifies rsp_valid: access faulted

Behaviour:
- Little-endian lanes: lane = offset[1:0], where offset = req_addr - BASE_ADDR (32-bit, wrapping).
- Word index = offset[DEPTH_LOG2+1:2].
- Range fault when offset >= 4*2^DEPTH_LOG2, including negative offsets that wrap.
- req_size = 3 always faults.
- FSM states: IDLE, ACCESS, CAPTURE, RESP, ERR. req_ready = 1 only in IDLE.
- IDLE: when req_valid is high, latch all req_* fields.
  - Faulting request -> ERR.
  - Otherwise -> ACCESS.
- ACCESS: ram_addr = latched index.
  - Store: ram_we = 1; ram_be = 4'b0001<<lane (byte), 4'b0011<<lane (half), 4'b1111 (word).
  - Store data: ram_wdata = wdata replicated (byte: 4 copies; half: 2 copies).
  - Store -> RESP. Load: ram_we = 0 -> CAPTURE.
- CAPTURE: select the byte/half at the lane from ram_rdata, extend per req_sign, register into rsp_rdata -> RESP.
- RESP: rsp_valid = 1, rsp_err = 0 -> IDLE.
- ERR: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, no RAM write -> IDLE.
- Latency from the accept edge:
  - store: ram_we in cycle +1, rsp_valid in cycle +2;
  - load: rsp_valid in cycle +3;
  - fault: rsp_valid in cycle +1.
- Throughput: at most one request in flight. A new request can be accepted in the cycle after rsp_valid.
- ram_we, ram_be and rsp_valid are 0 outside the states that drive them. ram_addr and ram_wdata hold their last values.
- Reset values: state = IDLE, req_ready = 1, ram_we = 0, ram_be = 0, ram_addr = 0, ram_wdata = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
- Reset mid-access: return to IDLE next edge. A pending write is dropped if reset coincides with ACCESS; no response is issued.
- req_sign is ignored for stores and for word loads.

Optional Feature:
- Macro: MEM_ACCESS_UNIT_ALIGN_CHECK_EN.
- Defined: misaligned access faults to ERR with no RAM access. Misaligned means half with lane[0] = 1, or word with lane != 0.
- Undefined: no alignment fault; the lane is truncated to the access size (half: lane & 2; word: lane = 0). Range and size checks remain.

Test Plan:
- Store word: BASE = 0, SW addr 0x10, data 0xDEADBEEF -> cycle +1: ram_addr = 4, ram_be = 1111, ram_wdata = DEADBEEF; cycle +2: rsp_valid = 1, rsp_err = 0.
- Store byte, then signed load: SB addr 0x13, data 0x80 -> ram_be = 1000. Then LB signed addr 0x13 -> rsp_rdata = 0xFFFFFF80 at cycle +3.
- Unsigned half load: RAM word 4 = 0x8001_1234; LHU addr 0x12 -> 0x00008001. LH addr 0x12 -> 0xFFFF8001.
- Range fault: BASE = 0x1000_0000, DEPTH_LOG2 = 11.
  - LW addr 0x1000_2000 -> rsp_valid, rsp_err = 1 at cycle +1, ram_we never asserted.
  - LW addr 0x0FFF_FFFC -> same response.
- Misalignment: LW addr 0x11.
  - With macro: rsp_err = 1.
  - Without macro: reads word 4, rsp_err = 0.
- Reset during ACCESS of SW -> no ram_we pulse, no rsp_valid; req_ready = 1 on the following cycle.
